// File: rtl/led_pattern_ctl.sv
// Multi-channel LED pattern controller: per-channel mode/duty registers, shared phase
// prescaler and PWM counter. Define LED_BREATHE_EN to enable the triangle-wave breathe mode (5).
module led_pattern_ctl #(
   parameter int NUM_LED  = 2,
   parameter int PRESCALE = 1000000,
   parameter int PWM_W    = 8,
   parameter int ADDR_W   = 5
) (
   input  logic               xclk,
   input  logic               sys_rst,
   input  logic               wr_en,
   input  logic [ADDR_W-1:0]  wr_addr,
   input  logic [7:0]         wr_data,
   input  logic [ADDR_W-1:0]  rd_addr,
   output logic [7:0]         rd_data,
   output logic               tick,
   output logic [NUM_LED-1:0] led
);

   localparam int              PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   localparam logic [2:0] MODE_OFF       = 3'd0;
   localparam logic [2:0] MODE_ON        = 3'd1;
   localparam logic [2:0] MODE_BLINK     = 3'd2;
   localparam logic [2:0] MODE_BLINK_INV = 3'd3;
   localparam logic [2:0] MODE_PWM       = 3'd4;
   localparam logic [2:0] MODE_BREATHE   = 3'd5;

   // Duty registers are PWM_W wide but travel over an 8-bit bus.
   function automatic logic [PWM_W-1:0] to_duty(input logic [7:0] d);
      logic [PWM_W-1:0] r;
      r = '0;
      for (int i = 0; i < PWM_W && i < 8; i++) r[i] = d[i];
      return r;
   endfunction

   function automatic logic [7:0] from_duty(input logic [PWM_W-1:0] d);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < PWM_W && i < 8; i++) r[i] = d[i];
      return r;
   endfunction

   logic                enable;
   logic [2:0]          mode [NUM_LED];
   logic [PWM_W-1:0]    duty [NUM_LED];
   logic [PS_W-1:0]     presc_cnt;
   logic [PWM_W-1:0]    phase;
   logic [PWM_W-1:0]    pwm_cnt;
   logic                ctrl_wr;
   logic                restart;
   logic [7:0]          rd_next;
   logic [NUM_LED-1:0]  led_next;

   assign ctrl_wr = wr_en && (wr_addr == '0);
   assign restart = ctrl_wr && wr_data[1];

   // Restart suppresses a coincident tick so phase never advances on that edge.
   assign tick = enable && (presc_cnt == PS_LAST) && !restart;

   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) begin
         presc_cnt <= '0;
         phase     <= '0;
      end else if (restart) begin
         presc_cnt <= '0;
         phase     <= '0;
      end else if (enable) begin
         if (presc_cnt == PS_LAST) begin
            presc_cnt <= '0;
            phase     <= phase + PWM_W'(1);
         end else begin
            presc_cnt <= presc_cnt + PS_W'(1);
         end
      end
   end

   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) pwm_cnt <= '0;
      else         pwm_cnt <= pwm_cnt + PWM_W'(1);
   end

   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) begin
         enable <= 1'b1;
         for (int k = 0; k < NUM_LED; k++) begin
            mode[k] <= MODE_OFF;
            duty[k] <= to_duty(8'h80);
         end
      end else if (wr_en) begin
         if (ctrl_wr) enable <= wr_data[0];
         for (int k = 0; k < NUM_LED; k++) begin
            if (wr_addr == ADDR_W'(2*k + 1)) mode[k] <= wr_data[2:0];
            if (wr_addr == ADDR_W'(2*k + 2)) duty[k] <= to_duty(wr_data);
         end
      end
   end

   always_comb begin
      rd_next = '0;
      if (rd_addr == '0) rd_next = {7'd0, enable};
      for (int k = 0; k < NUM_LED; k++) begin
         if (rd_addr == ADDR_W'(2*k + 1)) rd_next = {5'd0, mode[k]};
         if (rd_addr == ADDR_W'(2*k + 2)) rd_next = from_duty(duty[k]);
      end
   end

   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) rd_data <= '0;
      else         rd_data <= rd_next;
   end

`ifdef LED_BREATHE_EN
   // Triangle over one phase period: ramps up in the first half, down in the second.
   logic [PWM_W-1:0] breathe_duty;
   always_comb begin
      breathe_duty = phase[PWM_W-1] ? ~(phase << 1) : (phase << 1);
   end
`endif

   always_comb begin
      led_next = '0;
      for (int k = 0; k < NUM_LED; k++) begin
         case (mode[k])
            MODE_OFF:       led_next[k] = 1'b0;
            MODE_ON:        led_next[k] = 1'b1;
            MODE_BLINK:     led_next[k] = phase[0];
            MODE_BLINK_INV: led_next[k] = ~phase[0];
            MODE_PWM:       led_next[k] = (pwm_cnt < duty[k]);
`ifdef LED_BREATHE_EN
            MODE_BREATHE:   led_next[k] = (pwm_cnt < breathe_duty);
`else
            MODE_BREATHE:   led_next[k] = 1'b0;
`endif
            default:        led_next[k] = 1'b0;
         endcase
      end
   end

   always_ff @(posedge xclk or posedge sys_rst) begin
      if (sys_rst) led <= '0;
      else         led <= led_next;
   end

endmodule
